// File: rtl/riscv_pkg.sv
// Constants shared between the fetch stage and Control_Unit.
package riscv_pkg;

  localparam logic [31:0]  NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0]  RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam int unsigned  ADDR_W_DEFAULT   = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset and flush insert a NOP bubble, hold freezes contents.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic [31:0]       instr_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] pc_plus4_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic              valid_o
);

  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_plus4_q, pc_plus4_d;
  logic              valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (hold_i) begin
      // keep everything
    end else if (flush_i) begin
      instr_d    = NOP_INSTR;
      pc_d       = '0;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end else begin
      instr_d    = instr_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_plus4_i;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, next-PC selection with decode redirects, and the IF/ID register.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              PCsrc,
  input  logic              JUMPRT,
  input  logic [31:0]       ImmExt,
  input  logic [31:0]       RD1,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       instr_d,
  output logic [ADDR_W-1:0] pc_d,
  output logic [ADDR_W-1:0] pc_plus4_d,
  output logic              valid_d,
  output logic              misalign
);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, pc_plus4_f, target;
  logic [31:0]       jalr_sum;
  logic              misalign_q, misalign_d, redirect;

  // A bubble in decode can never redirect, so a redirect is always followed by one.
  assign redirect   = PCsrc & valid_d & ~stall;
  assign jalr_sum   = RD1 + ImmExt;
  assign target     = JUMPRT ? (ADDR_W'(jalr_sum) & ~ADDR_W'(1)) : (pc_d + ADDR_W'(ImmExt));
  assign pc_plus4_f = fetch_pc_q + ADDR_W'(4);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    misalign_d = misalign_q;
    if (stall) begin
      // hold
    end else if (redirect) begin
      fetch_pc_d = {target[ADDR_W-1:2], 2'b00};
      if (is_misaligned(target[1:0])) misalign_d = 1'b1;
    end else begin
      fetch_pc_d = pc_plus4_f;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      misalign_q <= misalign_d;
    end
  end

  if_id_reg #(
    .ADDR_W(ADDR_W)
  ) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .hold_i    (stall),
    .flush_i   (redirect),
    .instr_i   (imem_data),
    .pc_i      (fetch_pc_q),
    .pc_plus4_i(pc_plus4_f),
    .instr_o   (instr_d),
    .pc_o      (pc_d),
    .pc_plus4_o(pc_plus4_d),
    .valid_o   (valid_d)
  );

  assign imem_addr = fetch_pc_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a driver plays directed vectors and queues the
// hand-computed post-edge state; a monitor pops and compares after every clock edge.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        PCsrc;
  logic        JUMPRT;
  logic [31:0] ImmExt;
  logic [31:0] RD1;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        misalign;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic        mis;
  } exp_t;

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        pcsrc;
    logic        jumprt;
    logic [31:0] imm;
    logic [31:0] rd1;
    exp_t        exp;
  } vec_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vec_idx = 0;

  fetch_stage dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .PCsrc     (PCsrc),
    .JUMPRT    (JUMPRT),
    .ImmExt    (ImmExt),
    .RD1       (RD1),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .instr_d   (instr_d),
    .pc_d      (pc_d),
    .pc_plus4_d(pc_plus4_d),
    .valid_d   (valid_d),
    .misalign  (misalign)
  );

  // Instruction memory: the reset vector holds addi x1,x0,5; elsewhere addr ^ 0x13.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a == 32'hBFC0_0000) ? 32'h0050_0093 : (a ^ 32'h0000_0013);
  endfunction

  assign imem_data = imem_word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic s, input logic p, input logic j,
                     input logic [31:0] imm, input logic [31:0] rd1,
                     input logic [31:0] addr, input logic [31:0] instr,
                     input logic [31:0] pc, input logic [31:0] pc4,
                     input logic v, input logic m);
    vec_t t;
    t.rst = r; t.stall = s; t.pcsrc = p; t.jumprt = j; t.imm = imm; t.rd1 = rd1;
    t.exp.addr = addr; t.exp.instr = instr; t.exp.pc = pc; t.exp.pc4 = pc4;
    t.exp.valid = v; t.exp.mis = m;
    vecs.push_back(t);
  endtask

  // Monitor: compares DUT state #1 after each rising edge against the queued expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests++;
      if (imem_addr !== e.addr || instr_d !== e.instr || pc_d !== e.pc ||
          pc_plus4_d !== e.pc4 || valid_d !== e.valid || misalign !== e.mis) begin
        n_fail++;
        $display("FAIL vec%0d: got addr=%h instr=%h pc=%h pc4=%h v=%b mis=%b, want addr=%h instr=%h pc=%h pc4=%h v=%b mis=%b",
                 vec_idx, imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, misalign,
                 e.addr, e.instr, e.pc, e.pc4, e.valid, e.mis);
      end
      vec_idx++;
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; PCsrc = 1'b0; JUMPRT = 1'b0; ImmExt = '0; RD1 = '0;

    //   rst  stl  pcs  jrt  imm           rd1           addr          instr         pc            pc4           v     mis
    // Reset for two cycles
    add(1'b1,1'b0,1'b0,1'b0,32'h0,       32'h0,       32'hBFC00000,32'h00000013,32'h0,       32'h0,       1'b0,1'b0);
    add(1'b1,1'b0,1'b0,1'b0,32'h0,       32'h0,       32'hBFC00000,32'h00000013,32'h0,       32'h0,       1'b0,1'b0);
    // Sequential fetch
    add(1'b0,1'b0,1'b0,1'b0,32'h0,       32'h0,       32'hBFC00004,32'h00500093,32'hBFC00000,32'hBFC00004,1'b1,1'b0);
    add(1'b0,1'b0,1'b0,1'b0,32'h0,       32'h0,       32'hBFC00008,32'hBFC00017,32'hBFC00004,32'hBFC00008,1'b1,1'b0);
    add(1'b0,1'b0,1'b0,1'b0,32'h0,       32'h0,       32'hBFC0000C,32'hBFC0001B,32'hBFC00008,32'hBFC0000C,1'b1,1'b0);
    // Branch back by 8 from pc_d=BFC00008, then PCsrc left high on the bubble
    add(1'b0,1'b0,1'b1,1'b0,32'hFFFFFFF8,32'h0,       32'hBFC00000,32'h00000013,32'h0,       32'h0,       1'b0,1'b0);
    add(1'b0,1'b0,1'b1,1'b0,32'h00000100,32'h0,       32'hBFC00004,32'h00500093,32'hBFC00000,32'hBFC00004,1'b1,1'b0);
    // JALR to BFC00102: fetch from BFC00100, misalign sticks
    add(1'b0,1'b0,1'b1,1'b1,32'h00000002,32'hBFC00101,32'hBFC00100,32'h00000013,32'h0,       32'h0,       1'b0,1'b1);
    add(1'b0,1'b0,1'b0,1'b0,32'h0,       32'h0,       32'hBFC00104,32'hBFC00113,32'hBFC00100,32'hBFC00104,1'b1,1'b1);
    add(1'b0,1'b0,1'b0,1'b0,32'h0,       32'h0,       32'hBFC00108,32'hBFC00117,32'hBFC00104,32'hBFC00108,1'b1,1'b1);
    // Stall three cycles with a pending redirect, then release
    add(1'b0,1'b1,1'b1,1'b0,32'h00000010,32'h0,       32'hBFC00108,32'hBFC00117,32'hBFC00104,32'hBFC00108,1'b1,1'b1);
    add(1'b0,1'b1,1'b1,1'b0,32'h00000010,32'h0,       32'hBFC00108,32'hBFC00117,32'hBFC00104,32'hBFC00108,1'b1,1'b1);
    add(1'b0,1'b1,1'b1,1'b0,32'h00000010,32'h0,       32'hBFC00108,32'hBFC00117,32'hBFC00104,32'hBFC00108,1'b1,1'b1);
    add(1'b0,1'b0,1'b1,1'b0,32'h00000010,32'h0,       32'hBFC00114,32'h00000013,32'h0,       32'h0,       1'b0,1'b1);
    add(1'b0,1'b0,1'b0,1'b0,32'h0,       32'h0,       32'hBFC00118,32'hBFC00107,32'hBFC00114,32'hBFC00118,1'b1,1'b1);
    // Reset during a redirect cycle
    add(1'b1,1'b0,1'b1,1'b0,32'h00000040,32'h0,       32'hBFC00000,32'h00000013,32'h0,       32'h0,       1'b0,1'b0);
    add(1'b0,1'b0,1'b0,1'b0,32'h0,       32'h0,       32'hBFC00004,32'h00500093,32'hBFC00000,32'hBFC00004,1'b1,1'b0);
    // JALR to FFFFFFFC then wrap to 0
    add(1'b0,1'b0,1'b1,1'b1,32'h0000000C,32'hFFFFFFF0,32'hFFFFFFFC,32'h00000013,32'h0,       32'h0,       1'b0,1'b0);
    add(1'b0,1'b0,1'b0,1'b0,32'h0,       32'h0,       32'h00000000,32'hFFFFFFEF,32'hFFFFFFFC,32'h00000000,1'b1,1'b0);
    add(1'b0,1'b0,1'b0,1'b0,32'h0,       32'h0,       32'h00000004,32'h00000013,32'h00000000,32'h00000004,1'b1,1'b0);
    // JALR target with only bit 0 set: cleared, not misaligned
    add(1'b0,1'b0,1'b1,1'b1,32'h0,       32'h00000021,32'h00000020,32'h00000013,32'h0,       32'h0,       1'b0,1'b0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst    = vecs[i].rst;
      stall  = vecs[i].stall;
      PCsrc  = vecs[i].pcsrc;
      JUMPRT = vecs[i].jumprt;
      ImmExt = vecs[i].imm;
      RD1    = vecs[i].rd1;
      exp_q.push_back(vecs[i].exp);
    end
    @(negedge clk);
    rst = 1'b0; stall = 1'b0; PCsrc = 1'b0; JUMPRT = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
